// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell, the subtraction counterpart of the adder's full-adder cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial n-bit subtractor, d = x - y - bi, LSB first, one bit per clock.
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one operand bit per edge through the full-subtractor cell
//   DONE  | one-cycle done pulse; start here launches the next operation
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int n = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         bi,
    output logic [n-1:0] d,
    output logic         bo,
    output logic         busy,
    output logic         done
);

    localparam int            CW   = $clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    state_e         state_q, state_d;
    logic [n-1:0]   a_q, a_d;
    logic [n-1:0]   b_q, b_d;
    logic [n-1:0]   res_q, res_d;
    logic [n-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           br_q, br_d;
    logic           bo_q, bo_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           fs_diff;
    logic           fs_bout;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = x;
                    b_d     = y;
                    br_d    = bi;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d = {fs_diff, res_q[n-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_bout;
                cnt_d = cnt_q + 1'b1;
                // The last bit completes the result; publish it only now so d/bo never show partials.
                if (cnt_q == LAST) begin
                    d_d     = {fs_diff, res_q[n-1:1]};
                    bo_d    = fs_bout;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d    = d_q;
    assign bo   = bo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (n=4) with hand-computed results and an adder cross-check.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         bi;
    logic [N-1:0] d;
    logic         bo;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_done = 0;
    int t_first = 0;

    logic [N-1:0] prev_d  = '0;
    logic         prev_bo = 1'b0;

    serial_subtractor #(.n(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .bi    (bi),
        .d     (d),
        .bo    (bo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [N-1:0] xv, input logic [N-1:0] yv, input logic biv);
        x     = xv;
        y     = yv;
        bi    = biv;
        start = 1'b1;
    endtask

    // Called on the negedge where start is driven; returns on the negedge where done is seen
    // (or after the tail window when tail is set).
    task automatic await_op(input logic [N-1:0] xv, input logic [N-1:0] yv, input logic biv,
                            input logic [N-1:0] ed, input logic eb, input string tag,
                            input bit disturb, input bit tail);
        int i;
        logic [N:0] s5;
        i = 0;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && i < 20) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_hold_d"}, 32'(d), 32'(prev_d));
            check({tag, "_hold_bo"}, 32'(bo), 32'(prev_bo));
            if (disturb && i == 1) begin
                x     = ~xv;
                y     = ~yv;
                bi    = ~biv;
                start = 1'b1;
            end
            if (disturb && i == 2) start = 1'b0;
            @(negedge clk);
            i++;
        end
        t_done = cyc;
        check({tag, "_latency"}, 32'(i), 32'(N));
        check({tag, "_d"}, 32'(d), 32'(ed));
        check({tag, "_bo"}, 32'(bo), 32'(eb));
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        s5 = {1'b0, d} + {1'b0, yv} + {{N{1'b0}}, biv};
        check({tag, "_xchk_s"}, 32'(s5[N-1:0]), 32'(xv));
        check({tag, "_xchk_cu"}, 32'(s5[N]), 32'(eb));
        prev_d  = ed;
        prev_bo = eb;
        if (tail) begin
            repeat (N + 2) begin
                @(negedge clk);
                check({tag, "_done_low"}, 32'(done), 32'd0);
                check({tag, "_busy_idle"}, 32'(busy), 32'd0);
                check({tag, "_keep_d"}, 32'(d), 32'(ed));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        bi    = 1'b0;

        #2;
        check("rst_d", 32'(d), 32'd0);
        check("rst_bo", 32'(bo), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk); launch(4'b0101, 4'b0011, 1'b0);
        await_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, "basic", 1'b0, 1'b1);

        @(negedge clk); launch(4'b0000, 4'b0001, 1'b0);
        await_op(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, "uflow0", 1'b0, 1'b1);

        @(negedge clk); launch(4'b0010, 4'b0011, 1'b1);
        await_op(4'b0010, 4'b0011, 1'b1, 4'b1110, 1'b1, "uflow1", 1'b0, 1'b1);

        @(negedge clk); launch(4'b1111, 4'b1111, 1'b1);
        await_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "all_ones", 1'b0, 1'b1);

        @(negedge clk); launch(4'b0000, 4'b0000, 1'b0);
        await_op(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "zeros", 1'b0, 1'b1);

        @(negedge clk); launch(4'b1001, 4'b0100, 1'b0);
        await_op(4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, "disturb", 1'b1, 1'b1);

        // Back-to-back: second start driven in the DONE cycle of the first.
        @(negedge clk); launch(4'b0111, 4'b0010, 1'b0);
        await_op(4'b0111, 4'b0010, 1'b0, 4'b0101, 1'b0, "b2b_a", 1'b0, 1'b0);
        t_first = t_done;
        launch(4'b0011, 4'b0101, 1'b0);
        await_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, "b2b_b", 1'b0, 1'b1);
        check("b2b_spacing", 32'(t_done - t_first), 32'd5);

        // Abort: asynchronous reset in the second RUN cycle, checked before any clock edge.
        @(negedge clk); launch(4'b0110, 4'b0001, 1'b0);
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_d", 32'(d), 32'd0);
        check("abort_bo", 32'(bo), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_d  = '0;
        prev_bo = 1'b0;
        repeat (N + 2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_no_d", 32'(d), 32'd0);
        end
        launch(4'b1000, 4'b0001, 1'b0);
        await_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, "after_abort", 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
